vc_dispatch_ctrl: RTL

- Scheduler between the main FIFO and the two class FIFOs (VC0/VC1) that produce data_out0/data_out1.
- Pops the main FIFO head word and routes it by its class bit to the VC0 or VC1 push interface.
- Applies per-class pause with hysteresis using programmable high/low thresholds against class-FIFO occupancy.
- Thresholds are loaded in an INIT state.

---
 rtl/vc_dispatch_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/vc_dispatch_ctrl.sv
// vc_dispatch_ctrl: routes main-FIFO head words to VC0/VC1 with hysteresis pause.
// Define VC_DISPATCH_CNT_EN to enable the saturating dispatch counters cnt0/cnt1.
module vc_dispatch_ctrl #(
    parameter int DATA_SIZE = 6,
    parameter int DEST_BIT  = 5,
    parameter int CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic [CNT_W-1:0]     umbral_hi,
    input  logic [CNT_W-1:0]     umbral_lo,
    input  logic                 main_empty,
    input  logic [DATA_SIZE-1:0] main_data,
    output logic                 main_pop,
    input  logic [CNT_W-1:0]     q0_count,
    input  logic [CNT_W-1:0]     q1_count,
    output logic                 push0,
    output logic                 push1,
    output logic [DATA_SIZE-1:0] data_out0,
    output logic [DATA_SIZE-1:0] data_out1,
    output logic [1:0]           state,
    output logic                 cfg_err,
    output logic [7:0]           cnt0,
    output logic [7:0]           cnt1
);

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     hi_q, hi_d;
    logic [CNT_W-1:0]     lo_q, lo_d;
    logic                 pause0_q, pause0_d;
    logic                 pause1_q, pause1_d;
    logic                 cfg_err_q, cfg_err_d;
    logic                 push0_q, push0_d;
    logic                 push1_q, push1_d;
    logic [DATA_SIZE-1:0] dout0_q, dout0_d;
    logic [DATA_SIZE-1:0] dout1_q, dout1_d;
    logic [CNT_W:0]       eff0, eff1;
    logic                 run, head_cls, head_paused;

    assign run         = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
    assign head_cls    = main_data[DEST_BIT];
    assign head_paused = head_cls ? pause1_q : pause0_q;
    assign main_pop    = run & ~init & ~main_empty & ~cfg_err_q & ~head_paused;

    // Occupancy includes the push still in flight to the class FIFO.
    assign eff0 = {1'b0, q0_count} + {{CNT_W{1'b0}}, push0_q};
    assign eff1 = {1'b0, q1_count} + {{CNT_W{1'b0}}, push1_q};

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pause0_d  = pause0_q;
        pause1_d  = pause1_q;
        cfg_err_d = cfg_err_q;
        push0_d   = 1'b0;
        push1_d   = 1'b0;
        dout0_d   = dout0_q;
        dout1_d   = dout1_q;
        unique case (state_q)
            ST_RESET: begin
                state_d = ST_INIT;
            end
            ST_INIT: begin
                hi_d      = umbral_hi;
                lo_d      = umbral_lo;
                cfg_err_d = umbral_lo > umbral_hi;
                if (!init) state_d = ST_IDLE;
            end
            ST_IDLE, ST_ACTIVE: begin
                if (eff0 >= {1'b0, hi_q})      pause0_d = 1'b1;
                else if (eff0 <= {1'b0, lo_q}) pause0_d = 1'b0;
                if (eff1 >= {1'b0, hi_q})      pause1_d = 1'b1;
                else if (eff1 <= {1'b0, lo_q}) pause1_d = 1'b0;
                if (init)          state_d = ST_INIT;
                else if (main_pop) state_d = ST_ACTIVE;
                else               state_d = ST_IDLE;
                if (main_pop) begin
                    if (head_cls) begin
                        push1_d = 1'b1;
                        dout1_d = main_data;
                    end else begin
                        push0_d = 1'b1;
                        dout0_d = main_data;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RESET;
            hi_q      <= '0;
            lo_q      <= '0;
            pause0_q  <= 1'b0;
            pause1_q  <= 1'b0;
            cfg_err_q <= 1'b0;
            push0_q   <= 1'b0;
            push1_q   <= 1'b0;
            dout0_q   <= '0;
            dout1_q   <= '0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pause0_q  <= pause0_d;
            pause1_q  <= pause1_d;
            cfg_err_q <= cfg_err_d;
            push0_q   <= push0_d;
            push1_q   <= push1_d;
            dout0_q   <= dout0_d;
            dout1_q   <= dout1_d;
        end
    end

    assign push0     = push0_q;
    assign push1     = push1_q;
    assign data_out0 = dout0_q;
    assign data_out1 = dout1_q;
    assign state     = state_q;
    assign cfg_err   = cfg_err_q;

`ifdef VC_DISPATCH_CNT_EN
    logic [7:0] cnt0_q, cnt1_q;
    logic       init_entry;

    assign init_entry = (state_d == ST_INIT) && (state_q != ST_INIT);

    always_ff @(posedge clk) begin
        if (reset || init_entry) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (push0_d && cnt0_q != 8'hFF) cnt0_q <= cnt0_q + 8'd1;
            if (push1_d && cnt1_q != 8'hFF) cnt1_q <= cnt1_q + 8'd1;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`else
    assign cnt0 = '0;
    assign cnt1 = '0;
`endif

endmodule
